// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with per-channel tick and glitch-free reload.
// Build option CLKDIV_DUTY_EN: per-channel programmable high time (otherwise ~50% duty).
module clock_divider_multi #(
   parameter int unsigned WIDTH           = 28,
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned DEFAULT_DIVISOR = 100000
) (
   input  logic                clock_in,
   input  logic                reset,
   input  logic                en,
   input  logic                load,
   input  logic [3:0]          load_ch,
   input  logic [WIDTH-1:0]    load_div,
   input  logic [WIDTH-1:0]    load_high,
   output logic                load_err,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIVISOR);
   localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIVISOR - DEFAULT_DIVISOR / 2);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

   logic [WIDTH-1:0]    cnt_q  [CHANNELS];
   logic [WIDTH-1:0]    div_q  [CHANNELS];
   logic [WIDTH-1:0]    sdiv_q [CHANNELS];
   logic [WIDTH-1:0]    cnt_n  [CHANNELS];
   logic [WIDTH-1:0]    div_n  [CHANNELS];
   logic [WIDTH-1:0]    sdiv_n [CHANNELS];
   logic [CHANNELS-1:0] pend_n;
   logic [CHANNELS-1:0] clk_n;
   logic [CHANNELS-1:0] tick_n;
   logic                sel_pend_c;
   logic                load_ok_c;
   logic                load_err_n;

`ifdef CLKDIV_DUTY_EN
   logic [WIDTH-1:0] high_q  [CHANNELS];
   logic [WIDTH-1:0] shigh_q [CHANNELS];
   logic [WIDTH-1:0] high_n  [CHANNELS];
   logic [WIDTH-1:0] shigh_n [CHANNELS];

   // First count at which the output is high; high time is clamped to the period.
   function automatic logic [WIDTH-1:0] rise_at(input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] h);
      return d - ((h > d) ? d : h);
   endfunction
`else
   logic unused_load_high_c;
   assign unused_load_high_c = ^load_high;

   // Fixed high time div - div/2 puts the rising edge at div/2.
   function automatic logic [WIDTH-1:0] rise_at(input logic [WIDTH-1:0] d);
      return d >> 1;
   endfunction
`endif

   // Load acceptance: channel exists, is idle, and the divisor is usable.
   always_comb begin
      sel_pend_c = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (load_ch == 4'(i)) sel_pend_c = pending[i];
      end
      load_ok_c  = load && (32'(load_ch) < CHANNELS) && !sel_pend_c && (load_div >= TWO);
      load_err_n = load && !load_ok_c;
   end

   // Per-channel next state; outputs are derived from the next count so they
   // line up with the count held in the same cycle.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_n[i]  = cnt_q[i];
         div_n[i]  = div_q[i];
         sdiv_n[i] = sdiv_q[i];
         pend_n[i] = pending[i];
`ifdef CLKDIV_DUTY_EN
         high_n[i]  = high_q[i];
         shigh_n[i] = shigh_q[i];
`endif
         if (en) begin
            if (cnt_q[i] == div_q[i] - ONE) begin
               cnt_n[i] = '0;
               if (pending[i]) begin
                  div_n[i]  = sdiv_q[i];
                  pend_n[i] = 1'b0;
`ifdef CLKDIV_DUTY_EN
                  high_n[i] = shigh_q[i];
`endif
               end
            end else begin
               cnt_n[i] = cnt_q[i] + ONE;
            end
         end else if (pending[i]) begin
            cnt_n[i]  = '0;
            div_n[i]  = sdiv_q[i];
            pend_n[i] = 1'b0;
`ifdef CLKDIV_DUTY_EN
            high_n[i] = shigh_q[i];
`endif
         end

         // Accepted loads only target idle channels, so they never race an apply.
         if (load_ok_c && (load_ch == 4'(i))) begin
            sdiv_n[i] = load_div;
            pend_n[i] = 1'b1;
`ifdef CLKDIV_DUTY_EN
            shigh_n[i] = load_high;
`endif
         end

         tick_n[i] = en && (cnt_n[i] == div_n[i] - ONE);
`ifdef CLKDIV_DUTY_EN
         clk_n[i] = (cnt_n[i] >= rise_at(div_n[i], high_n[i]));
`else
         clk_n[i] = (cnt_n[i] >= rise_at(div_n[i]));
`endif
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= '0;
            div_q[i]  <= DEF_DIV;
            sdiv_q[i] <= DEF_DIV;
`ifdef CLKDIV_DUTY_EN
            high_q[i]  <= DEF_HIGH;
            shigh_q[i] <= DEF_HIGH;
`endif
         end
         pending   <= '0;
         clock_out <= '0;
         tick      <= '0;
         load_err  <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= cnt_n[i];
            div_q[i]  <= div_n[i];
            sdiv_q[i] <= sdiv_n[i];
`ifdef CLKDIV_DUTY_EN
            high_q[i]  <= high_n[i];
            shigh_q[i] <= shigh_n[i];
`endif
         end
         pending   <= pend_n;
         clock_out <= clk_n;
         tick      <= tick_n;
         load_err  <= load_err_n;
      end
   end

`ifndef CLKDIV_DUTY_EN
   logic unused_def_high_c;
   assign unused_def_high_c = ^DEF_HIGH;
`endif

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

- Parametrised, multi-channel successor to the single fixed-divisor clock divider.
- Generates CHANNELS independent divided clock-enable waveforms from one fabric clock.
- Divisor and high time are runtime-programmable per channel; updates are glitch-free and take effect at the period boundary.
- Sits between the board oscillator and LED blinkers, scanners and UART baud logic; each channel also provides a one-cycle tick per period.

## Interface
- WIDTH, 28, counter/divisor width in bits
- CHANNELS, 4, number of independent channels (1..16)
- DEFAULT_DIVISOR, 100000, reset divisor of every channel (≥2, < 2^WIDTH)
- clock_in  input  1  fabric clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- en  input  1  global run enable; low freezes all counters
- load  input  1  one-cycle request to program a channel
- load_ch  input  4  target channel index
- load_div  input  WIDTH  new divisor (period in clock_in cycles)
- load_high  input  WIDTH  new high time in cycles; used only with CLKDIV_DUTY_EN
- load_err  output  1  one-cycle pulse: load rejected
- pending  output  CHANNELS  per-channel flag: accepted update not yet applied
- clock_out  output  CHANNELS  divided waveforms
- tick  output  CHANNELS  one-cycle pulse on the last cycle of each period

## Operation
- Per channel: counter cnt, active div and high, shadow div/high, pending bit.
- Counting with en=1:
  - cnt increments each cycle.
  - In the cycle where cnt == div-1: cnt→0 and tick=1.
- High time:
  - Effective high h = min(high, div).
  - clock_out = (cnt >= div-h).
  - Low first, then high (legacy phase).
  - h=0 gives constant low; h=div gives constant high.
- Load acceptance:
  - A load is accepted when load_ch < CHANNELS, pending[load_ch]=0 and load_div ≥ 2.
  - Accepted: shadow ← load_div/load_high; pending[load_ch] ← 1 next cycle.
  - Any other load is rejected: load_err=1 the next cycle and no state changes.
- Apply, with en=1:
  - At wrap (cnt == div-1 and pending): div/high ← shadow, cnt→0, pending→0.
  - tick still fires for the completed period.
  - The new period starts on the following cycle.
- Apply, with en=0:
  - A pending update is applied on the next cycle.
  - cnt→0, pending→0, no tick.
- en=0 otherwise:
  - cnt, clock_out and tick are held; tick is forced 0.
- A load accepted in the same cycle as a wrap on that channel is not applied at that wrap; it waits for the next wrap.
- Channels are fully independent; simultaneous wraps on different channels are all handled.
- Width rule:
  - All comparisons are unsigned WIDTH-bit.
  - div-h never underflows because h ≤ div.
  - cnt never exceeds div-1.
- Reset, any cycle including mid-update:
  - cnt=0, div=DEFAULT_DIVISOR, high=DEFAULT_DIVISOR-DEFAULT_DIVISOR/2.
  - pending=0, clock_out=0, tick=0, load_err=0.
  - Pending shadows are discarded.

## Timing
- clock_out, tick, pending and load_err are driven directly from flops.
- clock_out and tick reflect cnt of the same cycle: the flop is loaded from next-state logic.
- Load latency: load in cycle t → pending=1 in t+1. The earliest apply is a wrap in t+1.
- After apply at wrap cycle w:
  - cycle w+1 has cnt=0 under the new div/high.
  - clock_out in w+1 follows the new setting.
- Period is exactly div cycles; tick spacing equals div while en stays high.
- No combinational path from any input to any output.

## Configuration
- CLKDIV_DUTY_EN defined:
  - load_high is used.
  - Each channel's high time is programmable, clamped to div.
- CLKDIV_DUTY_EN undefined:
  - load_high is ignored.
  - high is always div - div/2, i.e. clock_out = (cnt >= div/2); odd div gives one extra high cycle.
  - Shadow high registers are not built.
- Ports are identical in both builds.

## Test plan
- Reset and default period: DEFAULT_DIVISOR=4, en=1.
  - clock_out[0] = 0,0,1,1 repeating.
  - tick[0] pulses every 4th cycle, on the cycle with cnt=3.
  - All outputs 0 during reset.
- Glitch-free reprogram: load ch1 div=6 in mid-period.
  - pending[1]=1 until the current 4-cycle period ends.
  - Next period is 6 cycles: 0,0,0,1,1,1.
  - No short or long pulse at the boundary.
- Rejections: load_div=1, load_ch=7 with CHANNELS=4, or a second load to ch1 while pending[1]=1.
  - load_err pulses once per request.
  - No channel state changes.
- Duty (CLKDIV_DUTY_EN): ch2 div=5, high=1 gives 0,0,0,0,1. high=9 clamps to constant 1. high=0 gives constant 0.
- en low for 10 cycles mid-period:
  - cnt, clock_out held; no tick.
  - A pending load is applied the next cycle with cnt=0.
  - Resume with en=1 continues from the held or cleared count.
- Reset asserted while pending[0]=1:
  - Shadow is discarded; pending=0.
  - Channel returns to DEFAULT_DIVISOR timing.
